// File: rtl/multicycle_datapath.sv
// multicycle_datapath: multi-cycle core with FSM control, 8-entry register file, ALU, PC and req/ack memory ports
module multicycle_datapath #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int LINK_REG = 7
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [2:0]        dbg_reg_addr,
  output logic [DATA_W-1:0] dbg_reg_data,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire,
  output logic              halted,
  output logic              illegal_op
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
                         OP_ADDI = 5'd4, OP_LW = 5'd5, OP_SW = 5'd6, OP_BEQ = 5'd7,
                         OP_JAL = 5'd8, OP_HALT = 5'd31;
  state_t state;
  logic [31:0] ir;
  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] a, b, alu_q, mdr, alu, imm_ext, wr_val;
  logic [ADDR_W-1:0] pc, npc, pc4, imm_a;
  logic [4:0] op;
  logic [2:0] rs1, rt, rd, wr_idx;
  logic wr_en, bad_op, unused_bits;
  assign op = ir[31:27];
  assign rs1 = ir[26:24];
  assign rt = ir[23:21];
  assign rd = ir[20:18];
  assign unused_bits = ^ir[17:16];
  assign imm_ext = DATA_W'(signed'(ir[15:0]));
  assign imm_a = imm_ext[ADDR_W-1:0];
  assign pc4 = pc + ADDR_W'(4);
  assign bad_op = op > OP_JAL && op != OP_HALT;
  assign alu = op == OP_SUB ? a - b : op == OP_AND ? a & b : op == OP_OR ? a | b :
               op == OP_ADD ? a + b : a + imm_ext;
  assign wr_en = op <= OP_OR || op == OP_ADDI || op == OP_LW || op == OP_JAL;
  assign wr_idx = op <= OP_OR ? rd : op == OP_JAL ? 3'(LINK_REG) : rt;
  assign wr_val = op == OP_JAL ? DATA_W'(pc4) : op == OP_LW ? mdr : alu_q;
  // Requests decode straight from state; the fetch request is also gated by rst so it is low throughout reset
  assign imem_req = state == FETCH && !rst;
  assign imem_addr = pc;
  assign dmem_req = state == MEM;
  assign dmem_we = dmem_req && op == OP_SW;
  assign dmem_addr = alu_q[ADDR_W-1:0];
  assign dmem_wdata = b;
  assign dbg_reg_data = regs[dbg_reg_addr];
  assign pc_out = pc;
  assign retire = state == WB;
  assign halted = state == HALT;
  // Control FSM and all architectural/pipeline state; regs[0] is never written so R0 stays zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      npc <= '0;
      ir <= '0;
      a <= '0;
      b <= '0;
      alu_q <= '0;
      mdr <= '0;
      illegal_op <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: if (imem_ack) begin
          ir <= imem_rdata;
          state <= DECODE;
        end
        DECODE: begin
          a <= regs[rs1];
          b <= regs[rt];
          illegal_op <= bad_op;
          state <= (op == OP_HALT || bad_op) ? HALT : EXEC;
        end
        EXEC: begin
          alu_q <= alu;
          npc <= ((op == OP_BEQ && a == b) || op == OP_JAL) ? pc4 + (imm_a << 2) : pc4;
          state <= (op == OP_LW || op == OP_SW) ? MEM : WB;
        end
        MEM: if (dmem_ack) begin
          if (op == OP_LW) mdr <= dmem_rdata;
          state <= WB;
        end
        WB: begin
          if (wr_en && wr_idx != 3'd0) regs[wr_idx] <= wr_val;
          pc <= npc;
          state <= FETCH;
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: directed self-checking bench with wait-stated instruction/data memory models
module tb_multicycle_datapath;
  logic clk = 0, rst = 1;
  logic imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halted, illegal_op;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, dbg_reg_data, pc_out;
  logic [2:0] dbg_reg_addr = 0;
  logic [31:0] imem [16];
  logic [31:0] dmem [16];
  int iwait = 0, dwait = 0, iw = 0, dw = 0;
  int checks = 0, failures = 0;

  multicycle_datapath dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
    .pc_out(pc_out), .retire(retire), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign imem_ack = imem_req && iw >= iwait;
  assign imem_rdata = imem[imem_addr[5:2]];
  assign dmem_ack = dmem_req && dw >= dwait;
  assign dmem_rdata = dmem[dmem_addr[5:2]];

  always @(posedge clk) begin
    iw <= (imem_req && !imem_ack) ? iw + 1 : 0;
    dw <= (dmem_req && !dmem_ack) ? dw + 1 : 0;
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[5:2]] <= dmem_wdata;
  end

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [2:0] s, t, d, input logic [15:0] imm);
    return {op, s, t, d, 2'b00, imm};
  endfunction

  localparam logic [31:0] HLT = 32'hF800_0000;

  task automatic clear_imem;
    for (int i = 0; i < 16; i++) imem[i] = HLT;
  endtask

  task automatic do_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_halt(output int cyc, output int ret);
    cyc = 0;
    ret = 0;
    while (!halted && cyc < 500) begin
      step();
      cyc++;
      if (retire) ret++;
    end
  endtask

  task automatic test_reset;
    clear_imem();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pc_out !== 32'd0 || imem_req !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0)
      begin failures++; $display("FAIL reset_outs pc=%h ireq=%b dreq=%b we=%b exp 0", pc_out, imem_req, dmem_req, dmem_we); end
    checks++;
    if (retire !== 1'b0 || halted !== 1'b0 || illegal_op !== 1'b0)
      begin failures++; $display("FAIL reset_flags retire=%b halted=%b illegal=%b exp 0", retire, halted, illegal_op); end
    for (int i = 0; i < 8; i++) begin
      dbg_reg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_reg_data !== 32'd0) begin failures++; $display("FAIL reset_reg r%0d got=%h exp=0", i, dbg_reg_data); end
    end
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0)
      begin failures++; $display("FAIL reset_fetch ireq=%b addr=%h exp 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_add;
    int cyc, ret;
    iwait = 0; dwait = 0;
    clear_imem();
    imem[0] = enc(5'd4, 3'd0, 3'd1, 3'd0, 16'd5);
    imem[1] = enc(5'd4, 3'd0, 3'd2, 3'd0, 16'd3);
    imem[2] = enc(5'd0, 3'd1, 3'd2, 3'd3, 16'd0);
    do_reset();
    run_halt(cyc, ret);
    dbg_reg_addr = 3;
    #1;
    checks++;
    if (dbg_reg_data !== 32'd8) begin failures++; $display("FAIL add_r3 got=%h exp=8", dbg_reg_data); end
    checks++;
    if (ret != 3) begin failures++; $display("FAIL add_retires got=%0d exp=3", ret); end
    checks++;
    if (halted !== 1'b1 || pc_out !== 32'd12) begin failures++; $display("FAIL add_halt halted=%b pc=%h exp 1/c", halted, pc_out); end
    checks++;
    if (cyc != 14) begin failures++; $display("FAIL add_cycles got=%0d exp=14", cyc); end
    checks++;
    if (illegal_op !== 1'b0) begin failures++; $display("FAIL add_illegal got=%b exp=0", illegal_op); end
  endtask

  task automatic test_sub_r0;
    int cyc, ret;
    clear_imem();
    imem[0] = enc(5'd4, 3'd0, 3'd1, 3'd0, 16'd1);
    imem[1] = enc(5'd1, 3'd0, 3'd1, 3'd2, 16'd0);
    imem[2] = enc(5'd4, 3'd0, 3'd0, 3'd0, 16'd9);
    do_reset();
    run_halt(cyc, ret);
    dbg_reg_addr = 2;
    #1;
    checks++;
    if (dbg_reg_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sub_wrap got=%h exp=ffffffff", dbg_reg_data); end
    dbg_reg_addr = 0;
    #1;
    checks++;
    if (dbg_reg_data !== 32'd0) begin failures++; $display("FAIL r0_write got=%h exp=0", dbg_reg_data); end
    checks++;
    if (ret != 3 || pc_out !== 32'd12) begin failures++; $display("FAIL sub_run ret=%0d pc=%h exp 3/c", ret, pc_out); end
  endtask

  task automatic test_mem_wait;
    int n, cyc, ret;
    iwait = 3; dwait = 3;
    clear_imem();
    imem[0] = enc(5'd4, 3'd0, 3'd1, 3'd0, 16'h55);
    imem[1] = enc(5'd6, 3'd0, 3'd1, 3'd0, 16'd16);
    imem[2] = enc(5'd5, 3'd0, 3'd4, 3'd0, 16'd16);
    do_reset();
    n = 0;
    while (!dmem_req && n < 200) begin step(); n++; end
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'd16 || dmem_wdata !== 32'h55)
      begin failures++; $display("FAIL sw_req req=%b we=%b addr=%h wdata=%h exp 1/1/10/55", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'd16 || dmem_wdata !== 32'h55)
        begin failures++; $display("FAIL sw_stable w%0d req=%b we=%b addr=%h wdata=%h exp 1/1/10/55", i, dmem_req, dmem_we, dmem_addr, dmem_wdata); end
    end
    n = 0;
    while (!retire && n < 50) begin step(); n++; end
    n = 0;
    do begin step(); n++; end while (!retire && n < 50);
    checks++;
    if (n != 11) begin failures++; $display("FAIL lw_latency got=%0d exp=11", n); end
    run_halt(cyc, ret);
    dbg_reg_addr = 4;
    #1;
    checks++;
    if (dbg_reg_data !== 32'h55) begin failures++; $display("FAIL lw_r4 got=%h exp=55", dbg_reg_data); end
    checks++;
    if (dmem[4] !== 32'h55) begin failures++; $display("FAIL sw_mem got=%h exp=55", dmem[4]); end
    iwait = 0; dwait = 0;
  endtask

  task automatic test_branch;
    int n, cyc, ret;
    clear_imem();
    imem[0] = enc(5'd4, 3'd0, 3'd1, 3'd0, 16'd1);
    imem[1] = enc(5'd4, 3'd0, 3'd2, 3'd0, 16'd1);
    imem[2] = enc(5'd7, 3'd1, 3'd2, 3'd0, 16'hFFFF);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin step(); n++; end while (!retire && n < 50);
    end
    step();
    checks++;
    if (pc_out !== 32'd8 || halted !== 1'b0) begin failures++; $display("FAIL beq_taken pc=%h halted=%b exp 8/0", pc_out, halted); end
    clear_imem();
    imem[0] = enc(5'd4, 3'd0, 3'd1, 3'd0, 16'd1);
    imem[1] = enc(5'd4, 3'd0, 3'd2, 3'd0, 16'd2);
    imem[2] = enc(5'd7, 3'd1, 3'd2, 3'd0, 16'hFFFF);
    do_reset();
    run_halt(cyc, ret);
    checks++;
    if (pc_out !== 32'd12 || ret != 3) begin failures++; $display("FAIL beq_not_taken pc=%h ret=%0d exp c/3", pc_out, ret); end
    clear_imem();
    imem[0] = enc(5'd8, 3'd0, 3'd0, 3'd0, 16'd2);
    imem[1] = enc(5'd4, 3'd0, 3'd5, 3'd0, 16'd1);
    do_reset();
    run_halt(cyc, ret);
    dbg_reg_addr = 7;
    #1;
    checks++;
    if (pc_out !== 32'd12 || dbg_reg_data !== 32'd4) begin failures++; $display("FAIL jal pc=%h r7=%h exp c/4", pc_out, dbg_reg_data); end
    dbg_reg_addr = 5;
    #1;
    checks++;
    if (dbg_reg_data !== 32'd0) begin failures++; $display("FAIL jal_skip r5=%h exp=0", dbg_reg_data); end
  endtask

  task automatic test_illegal;
    int cyc, ret, bad;
    clear_imem();
    imem[0] = enc(5'd4, 3'd0, 3'd1, 3'd0, 16'd1);
    imem[1] = enc(5'b10101, 3'd0, 3'd0, 3'd0, 16'd0);
    do_reset();
    run_halt(cyc, ret);
    checks++;
    if (halted !== 1'b1 || illegal_op !== 1'b1) begin failures++; $display("FAIL illegal_flags halted=%b illegal=%b exp 1/1", halted, illegal_op); end
    checks++;
    if (ret != 1 || pc_out !== 32'd4) begin failures++; $display("FAIL illegal_pc ret=%0d pc=%h exp 1/4", ret, pc_out); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (imem_req !== 1'b0 || dmem_req !== 1'b0 || retire !== 1'b0 || pc_out !== 32'd4 || illegal_op !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL illegal_hold bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_reset_mid_mem;
    int n, cyc, ret;
    dwait = 3;
    clear_imem();
    imem[0] = enc(5'd4, 3'd0, 3'd1, 3'd0, 16'h55);
    imem[1] = enc(5'd6, 3'd0, 3'd1, 3'd0, 16'd20);
    do_reset();
    n = 0;
    while (!dmem_req && n < 200) begin step(); n++; end
    step();
    rst = 1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || imem_req !== 1'b0)
      begin failures++; $display("FAIL rst_async dreq=%b we=%b ireq=%b exp 0", dmem_req, dmem_we, imem_req); end
    for (int i = 0; i < 8; i++) begin
      dbg_reg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_reg_data !== 32'd0) begin failures++; $display("FAIL rst_reg r%0d got=%h exp=0", i, dbg_reg_data); end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0 || pc_out !== 32'd0)
      begin failures++; $display("FAIL rst_restart ireq=%b addr=%h pc=%h exp 1/0/0", imem_req, imem_addr, pc_out); end
    run_halt(cyc, ret);
    checks++;
    if (halted !== 1'b1 || pc_out !== 32'd8 || dmem[5] !== 32'h55)
      begin failures++; $display("FAIL rst_rerun halted=%b pc=%h mem=%h exp 1/8/55", halted, pc_out, dmem[5]); end
    dwait = 0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_r0();
    test_mem_wait();
    test_branch();
    test_illegal();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multi-cycle successor to the single-cycle core datapath.
- Contains an internal FSM control unit, an 8-entry register file, an ALU, and PC logic.
- Instruction and data memories are external and reached over req/ack handshakes, so wait-stated memories are tolerated.
- Sits between the memory subsystem and the top-level system; exposes a debug register read port for bring-up and verification.

Parameters:
DATA_W, 32, datapath/register/ALU width (>=16)
ADDR_W, 32, PC and memory address width (<=DATA_W)
RESET_PC, 0, PC value loaded on reset
LINK_REG, 7, register written by JAL

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch byte address (= pc)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  instruction word
dmem_req  out  1  data access request
dmem_we  out  1  1=store, 0=load; valid with dmem_req
dmem_addr  out  ADDR_W  data byte address
dmem_wdata  out  DATA_W  store data
dmem_ack  in  1  access complete (load data valid)
dmem_rdata  in  DATA_W  load data
dbg_reg_addr  in  3  debug read index
dbg_reg_data  out  DATA_W  combinational read of register dbg_reg_addr
pc_out  out  ADDR_W  current PC
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  core stopped (HALT or illegal)
illegal_op  out  1  sticky: stopped on undefined opcode

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - pc = RESET_PC.
  - All registers = 0.
  - FSM = FETCH.
  - All req/we outputs, retire, halted and illegal_op = 0.
  - Reset mid-handshake drops req immediately; the memory must tolerate an abandoned request.
- Instruction encoding: opcode[31:27], rs1[26:24], rt[23:21], rd[20:18], imm[15:0] sign-extended to DATA_W.
- Opcodes:
  - 00000 ADD rd=rs1+rt
  - 00001 SUB rd=rs1-rt
  - 00010 AND rd=rs1&rt
  - 00011 OR rd=rs1|rt
  - 00100 ADDI rt=rs1+imm
  - 00101 LW rt=mem[rs1+imm]
  - 00110 SW mem[rs1+imm]=rt
  - 00111 BEQ: if rs1==rt, pc=pc+4+(imm<<2)
  - 01000 JAL: LINK_REG=pc+4, pc=pc+4+(imm<<2)
  - 11111 HALT
  - Any other opcode is illegal.
- Arithmetic: wraps modulo 2^DATA_W, no flags. Addresses are the low ADDR_W bits of ALU results. PC arithmetic wraps modulo 2^ADDR_W.
- R0 reads as 0; writes to R0 are discarded.
- FSM states: FETCH -> DECODE -> EXEC -> (MEM) -> WB -> FETCH; HALT is terminal.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack, latch the instruction into IR and go to DECODE.
  - While ack=0, hold req and addr stable.
- DECODE:
  - Latch A=reg[rs1] and B=reg[rt].
  - HALT or illegal opcode -> HALT state; illegal also sets illegal_op.
- EXEC:
  - Compute the ALU result and branch target.
  - LW/SW -> MEM; all other opcodes -> WB.
- MEM:
  - dmem_req=1; dmem_we=1 for SW; dmem_addr=ALU result; dmem_wdata=B.
  - Hold all outputs stable until dmem_ack; on ack, latch dmem_rdata for LW and go to WB.
- WB:
  - Perform the register write (rd for R-type, rt for ADDI/LW, LINK_REG for JAL).
  - Update pc (pc+4, branch target, or jump target).
  - Pulse retire=1 and return to FETCH.
- Latency with zero-wait memory (ack in the same cycle as req): 4 cycles for ALU/branch/JAL, 5 cycles for LW/SW. Each wait cycle adds 1.
- HALT state:
  - halted=1; no requests are issued; pc stays at the HALT instruction.
  - Only rst exits HALT.
- The debug port reads the architectural state as of the last WB. A register being written in the current cycle shows its old value.

Test Plan:
- Reset then zero-wait: ADDI r1,r0,5; ADDI r2,r0,3; ADD r3,r1,r2; HALT -> dbg r3=8; retire pulses exactly 3 times; halted=1; pc_out=12; cycle count 4+4+4+2.
- SUB wrap and R0: ADDI r1,r0,1; SUB r2,r0,r1 -> r2=0xFFFFFFFF. ADDI r0,r0,9 -> r0 reads 0.
- Memory with 3 wait states on both ports: SW r1(=0x55) to [r0+16], then LW r4 from [r0+16] -> dmem_addr=16; req/addr/wdata stable over waits; r4=0x55; LW takes 5+3+3 cycles.
- Branches: BEQ taken with imm=-1 at pc=8 -> pc=8; not taken -> pc=12. JAL imm=2 at pc=0 -> pc=12; r7=4.
- Illegal opcode 10101 at pc=4 -> halted=1; illegal_op=1; no retire; imem_req=0 thereafter; pc_out=4.
- Assert rst during a MEM wait -> dmem_req drops the same cycle (asynchronously); all registers=0; fetch restarts at RESET_PC after rst deasserts.
